// File: rtl/fmc_adc_trig_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fmc_adc_trig_pkg
//   Shared definitions for the FMC-ADC trigger sequencer:
//     - bit positions of each trigger source inside the 7-bit source vectors
//     - sequencer state encoding (exported on a debug output)
//     - small helper to recognise an external-only hit
// ---------------------------------------------------------------------------
package fmc_adc_trig_pkg;

    localparam int c_NB_TRIG_SRC   = 7;
    localparam int c_TRIG_SRC_EXT  = 0;
    localparam int c_TRIG_SRC_SW   = 1;
    localparam int c_TRIG_SRC_TIME = 2;
    localparam int c_TRIG_SRC_CH1  = 3;
    localparam int c_TRIG_SRC_CH2  = 4;
    localparam int c_TRIG_SRC_CH3  = 5;
    localparam int c_TRIG_SRC_CH4  = 6;

    typedef logic [c_NB_TRIG_SRC-1:0] t_trig_vec;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DELAY = 2'd2
    } t_trig_seq_state;

    localparam t_trig_vec c_TRIG_EXT_ONLY = t_trig_vec'(1) << c_TRIG_SRC_EXT;

    // Only a pure external hit goes through the programmable delay; any mix
    // with another source fires at once.
    function automatic logic is_ext_only(input t_trig_vec v);
        return v == c_TRIG_EXT_ONLY;
    endfunction

endpackage

// File: rtl/fmc_adc_trig_sequencer_if.sv
// ---------------------------------------------------------------------------
// fmc_adc_trig_sequencer_if
//   Bundles the sequencer's control/status signals.
//   slave  : seen by the sequencer (arm/disarm/enables/sources/delay/clear in,
//            trigger/source/count/busy/missed/debug out)
//   master : seen by the acquisition FSM / register bank driving it
//   state_o and dly_cnt_o are debug taps of the FSM state and delay counter.
//   All inputs are single-cycle pulses or levels in the sys_clk domain; there
//   is no backpressure: trig_o and missed_o are one-cycle strobes that the
//   consumer must take in the cycle they are high.
// ---------------------------------------------------------------------------
interface fmc_adc_trig_sequencer_if #(
    parameter int g_DLY_WIDTH = 32,
    parameter int g_CNT_WIDTH = 32
) ();
    import fmc_adc_trig_pkg::*;

    logic                   arm_i;
    logic                   disarm_i;
    t_trig_vec              trig_en_i;
    t_trig_vec              trig_src_i;
    logic [g_DLY_WIDTH-1:0] ext_dly_i;
    logic                   cnt_clr_i;

    logic                   trig_o;
    t_trig_vec              trig_src_o;
    logic [g_CNT_WIDTH-1:0] trig_cnt_o;
    logic                   busy_o;
    logic                   missed_o;
    t_trig_seq_state        state_o;
    logic [g_DLY_WIDTH-1:0] dly_cnt_o;

    modport slave (
        input  arm_i, disarm_i, trig_en_i, trig_src_i, ext_dly_i, cnt_clr_i,
        output trig_o, trig_src_o, trig_cnt_o, busy_o, missed_o, state_o,
               dly_cnt_o
    );

    modport master (
        output arm_i, disarm_i, trig_en_i, trig_src_i, ext_dly_i, cnt_clr_i,
        input  trig_o, trig_src_o, trig_cnt_o, busy_o, missed_o, state_o,
               dly_cnt_o
    );

endinterface

// File: rtl/fmc_adc_trig_sequencer_dly_cnt.sv
// ---------------------------------------------------------------------------
// fmc_adc_trig_dly_cnt
//   Down-counter for the external-trigger delay.
//   Ports:
//     clk_i, rst_n_i : clock, synchronous active-low reset
//     load_i         : load load_val_i (takes priority over decrement)
//     load_val_i     : delay in cycles
//     dec_i          : decrement by one this cycle (saturates at 0)
//     clr_i          : force counter to 0 (highest priority)
//     done_o         : combinational, high in the cycle the count goes 1 -> 0
//     cnt_o          : current count
// ---------------------------------------------------------------------------
module fmc_adc_trig_dly_cnt #(
    parameter int g_DLY_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   load_i,
    input  logic [g_DLY_WIDTH-1:0] load_val_i,
    input  logic                   dec_i,
    input  logic                   clr_i,
    output logic                   done_o,
    output logic [g_DLY_WIDTH-1:0] cnt_o
);

    localparam logic [g_DLY_WIDTH-1:0] c_ONE = {{(g_DLY_WIDTH-1){1'b0}}, 1'b1};

    logic [g_DLY_WIDTH-1:0] cnt_q;
    logic [g_DLY_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - c_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = dec_i && !clr_i && (cnt_q == c_ONE);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/fmc_adc_trig_sequencer.sv
// ---------------------------------------------------------------------------
// fmc_adc_trig_sequencer
//   Trigger arbiter/sequencer between the trigger sources and the acquisition
//   FSM. Once armed, the first cycle with an enabled source pulse is accepted:
//   the active sources are latched on trig_src_o and a single registered
//   trig_o pulse is produced, either at once or, for an external-only hit with
//   a non-zero delay, after ext_dly_i cycles. Every fire returns to IDLE, so
//   the acquisition FSM must re-arm for each shot.
//   Ports:
//     sys_clk_i    : system clock
//     sys_rst_n_i  : synchronous active-low reset
//     seq          : fmc_adc_trig_sequencer_if.slave (all control/status)
// ---------------------------------------------------------------------------
module fmc_adc_trig_sequencer
    import fmc_adc_trig_pkg::*;
#(
    parameter int g_DLY_WIDTH = 32,
    parameter int g_CNT_WIDTH = 32
) (
    input  logic                     sys_clk_i,
    input  logic                     sys_rst_n_i,
    fmc_adc_trig_sequencer_if.slave  seq
);

    localparam logic [g_CNT_WIDTH-1:0] c_CNT_ONE = {{(g_CNT_WIDTH-1){1'b0}}, 1'b1};

    t_trig_seq_state        state_q;
    logic                   trig_q;
    logic                   missed_q;
    t_trig_vec              trig_src_q;
    logic [g_CNT_WIDTH-1:0] trig_cnt_q;

    t_trig_vec              hit;
    logic                   hit_any;
    logic                   dly_load;
    logic                   dly_dec;
    logic                   dly_clr;
    logic                   dly_done;
    logic                   fire;
    logic [g_DLY_WIDTH-1:0] dly_cnt;

    assign hit     = seq.trig_src_i & seq.trig_en_i;
    assign hit_any = |hit;

    // Enable mask and delay are only looked at in the accept cycle; after
    // that the pending trigger depends solely on the loaded counter.
    assign dly_load = (state_q == ARMED) && !seq.disarm_i &&
                      is_ext_only(hit) && (seq.ext_dly_i != '0);
    assign dly_dec  = (state_q == DELAY) && !seq.disarm_i;
    assign dly_clr  = (state_q == DELAY) && seq.disarm_i;

    // dly_done can only be high while decrementing, i.e. in DELAY without
    // a disarm, so an abort always suppresses the pending fire.
    assign fire = ((state_q == ARMED) && !seq.disarm_i && hit_any && !dly_load) ||
                  dly_done;

    fmc_adc_trig_dly_cnt #(
        .g_DLY_WIDTH (g_DLY_WIDTH)
    ) u_dly_cnt (
        .clk_i      (sys_clk_i),
        .rst_n_i    (sys_rst_n_i),
        .load_i     (dly_load),
        .load_val_i (seq.ext_dly_i),
        .dec_i      (dly_dec),
        .clr_i      (dly_clr),
        .done_o     (dly_done),
        .cnt_o      (dly_cnt)
    );

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            state_q    <= IDLE;
            trig_q     <= 1'b0;
            missed_q   <= 1'b0;
            trig_src_q <= '0;
            trig_cnt_q <= '0;
        end else begin
            trig_q   <= fire;
            // A source arriving while a delayed trigger is pending is lost;
            // report it but leave the pending trigger alone.
            missed_q <= (state_q == DELAY) && hit_any;

            if (seq.cnt_clr_i) begin
                trig_cnt_q <= '0;
            end else if (fire) begin
                trig_cnt_q <= trig_cnt_q + c_CNT_ONE;
            end

            case (state_q)
                IDLE: begin
                    if (seq.arm_i && !seq.disarm_i) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (seq.disarm_i) begin
                        state_q <= IDLE;
                    end else if (hit_any) begin
                        trig_src_q <= hit;
                        state_q    <= dly_load ? DELAY : IDLE;
                    end
                end
                DELAY: begin
                    if (seq.disarm_i || dly_done) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign seq.trig_o     = trig_q;
    assign seq.trig_src_o = trig_src_q;
    assign seq.trig_cnt_o = trig_cnt_q;
    assign seq.missed_o   = missed_q;
    assign seq.busy_o     = (state_q == ARMED) || (state_q == DELAY);
    assign seq.state_o    = state_q;
    assign seq.dly_cnt_o  = dly_cnt;

endmodule

// File: tb/tb_fmc_adc_trig_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fmc_adc_trig_sequencer
//   Directed scenarios for the trigger sequencer. Inputs change just after
//   the falling edge and outputs are observed at the following falling edge,
//   so "cycle t+k" below is the k-th falling edge after the one where a pulse
//   was applied. A second instance with a 3-bit trigger counter exercises the
//   counter wrap in a handful of shots.
// ---------------------------------------------------------------------------
module tb_fmc_adc_trig_sequencer;
    import fmc_adc_trig_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fmc_adc_trig_sequencer_if #(.g_DLY_WIDTH(32), .g_CNT_WIDTH(32)) bus ();
    fmc_adc_trig_sequencer_if #(.g_DLY_WIDTH(32), .g_CNT_WIDTH(3))  bus_w ();

    fmc_adc_trig_sequencer #(.g_DLY_WIDTH(32), .g_CNT_WIDTH(32)) dut (
        .sys_clk_i   (clk),
        .sys_rst_n_i (rst_n),
        .seq         (bus)
    );

    fmc_adc_trig_sequencer #(.g_DLY_WIDTH(32), .g_CNT_WIDTH(3)) dut_w (
        .sys_clk_i   (clk),
        .sys_rst_n_i (rst_n),
        .seq         (bus_w)
    );

    task automatic arm_pulse;
        bus.arm_i = 1'b1;
        @(negedge clk);
        bus.arm_i = 1'b0;
    endtask

    task automatic test_reset;
        bus.arm_i = 0; bus.disarm_i = 0; bus.trig_en_i = '0; bus.trig_src_i = '0;
        bus.ext_dly_i = '0; bus.cnt_clr_i = 0;
        bus_w.arm_i = 0; bus_w.disarm_i = 0; bus_w.trig_en_i = '0; bus_w.trig_src_i = '0;
        bus_w.ext_dly_i = '0; bus_w.cnt_clr_i = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.trig_o !== 1'b0) begin n_err++; $display("FAIL reset_trig: got %b expected 0", bus.trig_o); end
        n_vec++; if (bus.trig_src_o !== 7'b0) begin n_err++; $display("FAIL reset_src: got %b expected 0", bus.trig_src_o); end
        n_vec++; if (bus.trig_cnt_o !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", bus.trig_cnt_o); end
        n_vec++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
        n_vec++; if (bus.missed_o !== 1'b0) begin n_err++; $display("FAIL reset_missed: got %b expected 0", bus.missed_o); end
        n_vec++; if (bus.state_o !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", bus.state_o, IDLE); end
    endtask

    task automatic test_sw_only;
        bus.trig_en_i = 7'h7F;
        arm_pulse();
        n_vec++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL sw_armed_busy: got %b expected 1", bus.busy_o); end
        bus.trig_src_i = 7'b0000010;
        @(negedge clk);
        bus.trig_src_i = '0;
        n_vec++; if (bus.trig_o !== 1'b1) begin n_err++; $display("FAIL sw_trig: got %b expected 1", bus.trig_o); end
        n_vec++; if (bus.trig_src_o !== 7'b0000010) begin n_err++; $display("FAIL sw_src: got %b expected 0000010", bus.trig_src_o); end
        n_vec++; if (bus.trig_cnt_o !== 32'd1) begin n_err++; $display("FAIL sw_cnt: got %0d expected 1", bus.trig_cnt_o); end
        n_vec++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL sw_busy_after: got %b expected 0", bus.busy_o); end
        @(negedge clk);
        n_vec++; if (bus.trig_o !== 1'b0) begin n_err++; $display("FAIL sw_trig_single: got %b expected 0", bus.trig_o); end
    endtask

    task automatic test_ext_delay;
        int n_trig = 0, first = 0, n_miss = 0, miss_at = 0;
        bus.ext_dly_i = 32'd3;
        arm_pulse();
        bus.trig_src_i = 7'b0000001;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.trig_src_i = (k == 1) ? 7'b0001000 : 7'b0;
            if (bus.trig_o === 1'b1) begin n_trig++; if (first == 0) first = k; end
            if (bus.missed_o === 1'b1) begin n_miss++; if (miss_at == 0) miss_at = k; end
        end
        n_vec++; if (first !== 4) begin n_err++; $display("FAIL ext3_latency: got %0d expected 4", first); end
        n_vec++; if (n_trig !== 1) begin n_err++; $display("FAIL ext3_trig_count: got %0d expected 1", n_trig); end
        n_vec++; if (n_miss !== 1) begin n_err++; $display("FAIL ext3_missed_count: got %0d expected 1", n_miss); end
        n_vec++; if (miss_at !== 2) begin n_err++; $display("FAIL ext3_missed_at: got %0d expected 2", miss_at); end
        n_vec++; if (bus.trig_src_o !== 7'b0000001) begin n_err++; $display("FAIL ext3_src: got %b expected 0000001", bus.trig_src_o); end
        n_vec++; if (bus.trig_cnt_o !== 32'd2) begin n_err++; $display("FAIL ext3_cnt: got %0d expected 2", bus.trig_cnt_o); end
    endtask

    task automatic test_mixed;
        bus.ext_dly_i = 32'd10;
        arm_pulse();
        bus.trig_src_i = 7'b0100001;
        @(negedge clk);
        bus.trig_src_i = '0;
        n_vec++; if (bus.trig_o !== 1'b1) begin n_err++; $display("FAIL mixed_trig: got %b expected 1", bus.trig_o); end
        n_vec++; if (bus.trig_src_o !== 7'b0100001) begin n_err++; $display("FAIL mixed_src: got %b expected 0100001", bus.trig_src_o); end
        n_vec++; if (bus.trig_cnt_o !== 32'd3) begin n_err++; $display("FAIL mixed_cnt: got %0d expected 3", bus.trig_cnt_o); end
    endtask

    task automatic test_ext_short;
        int first;
        for (int d = 0; d <= 1; d++) begin
            first = 0;
            bus.ext_dly_i = d;
            arm_pulse();
            bus.trig_src_i = 7'b0000001;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                bus.trig_src_i = '0;
                if (bus.trig_o === 1'b1 && first == 0) first = k;
            end
            n_vec++; if (first !== d + 1) begin n_err++; $display("FAIL ext_dly%0d_latency: got %0d expected %0d", d, first, d + 1); end
        end
        n_vec++; if (bus.trig_cnt_o !== 32'd5) begin n_err++; $display("FAIL ext_short_cnt: got %0d expected 5", bus.trig_cnt_o); end
    endtask

    task automatic test_multi_shot;
        int n_trig = 0, n_miss = 0;
        bus.cnt_clr_i = 1'b1;
        @(negedge clk);
        bus.cnt_clr_i = 1'b0;
        n_vec++; if (bus.trig_cnt_o !== 32'd0) begin n_err++; $display("FAIL multi_clr: got %0d expected 0", bus.trig_cnt_o); end
        for (int s = 0; s < 3; s++) begin
            arm_pulse();
            bus.trig_src_i = 7'b0000010;
            @(negedge clk);
            bus.trig_src_i = '0;
            if (bus.trig_o === 1'b1) n_trig++;
            @(negedge clk);
            if (bus.trig_o === 1'b1) n_trig++;
        end
        n_vec++; if (n_trig !== 3) begin n_err++; $display("FAIL multi_trig_count: got %0d expected 3", n_trig); end
        n_vec++; if (bus.trig_cnt_o !== 32'd3) begin n_err++; $display("FAIL multi_cnt: got %0d expected 3", bus.trig_cnt_o); end
        n_trig = 0;
        bus.trig_src_i = 7'b0000010;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus.trig_src_i = '0;
            if (bus.trig_o === 1'b1) n_trig++;
            if (bus.missed_o === 1'b1) n_miss++;
        end
        n_vec++; if (n_trig !== 0) begin n_err++; $display("FAIL idle_sw_trig: got %0d expected 0", n_trig); end
        n_vec++; if (n_miss !== 0) begin n_err++; $display("FAIL idle_sw_missed: got %0d expected 0", n_miss); end
    endtask

    task automatic test_abort;
        int n_trig = 0;
        bus.ext_dly_i = 32'd100;
        arm_pulse();
        bus.trig_src_i = 7'b0000001;
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk);
            bus.trig_src_i = '0;
            bus.disarm_i = (k == 20);
            if (bus.trig_o === 1'b1) n_trig++;
            if (k == 19) begin
                n_vec++; if (bus.state_o !== DELAY) begin n_err++; $display("FAIL abort_in_delay: got %0d expected %0d", bus.state_o, DELAY); end
            end
        end
        n_vec++; if (n_trig !== 0) begin n_err++; $display("FAIL abort_trig: got %0d expected 0", n_trig); end
        n_vec++; if (bus.state_o !== IDLE) begin n_err++; $display("FAIL abort_state: got %0d expected %0d", bus.state_o, IDLE); end
        n_vec++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", bus.busy_o); end
        n_vec++; if (bus.trig_cnt_o !== 32'd3) begin n_err++; $display("FAIL abort_cnt: got %0d expected 3", bus.trig_cnt_o); end
        n_vec++; if (bus.trig_src_o !== 7'b0000001) begin n_err++; $display("FAIL abort_src: got %b expected 0000001", bus.trig_src_o); end
        n_vec++; if (bus.dly_cnt_o !== 32'd0) begin n_err++; $display("FAIL abort_dly_cnt: got %0d expected 0", bus.dly_cnt_o); end
    endtask

    task automatic test_arm_edges;
        bus.arm_i = 1'b1; bus.disarm_i = 1'b1;
        @(negedge clk);
        bus.arm_i = 1'b0; bus.disarm_i = 1'b0;
        n_vec++; if (bus.state_o !== IDLE) begin n_err++; $display("FAIL arm_disarm_state: got %0d expected %0d", bus.state_o, IDLE); end
        n_vec++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL arm_disarm_busy: got %b expected 0", bus.busy_o); end
        bus.arm_i = 1'b1; bus.trig_src_i = 7'b0000010;
        @(negedge clk);
        bus.arm_i = 1'b0; bus.trig_src_i = '0;
        n_vec++; if (bus.state_o !== ARMED) begin n_err++; $display("FAIL arm_hit_state: got %0d expected %0d", bus.state_o, ARMED); end
        @(negedge clk);
        n_vec++; if (bus.trig_o !== 1'b0) begin n_err++; $display("FAIL arm_hit_trig: got %b expected 0", bus.trig_o); end
        bus.disarm_i = 1'b1;
        @(negedge clk);
        bus.disarm_i = 1'b0;
        n_vec++; if (bus.state_o !== IDLE) begin n_err++; $display("FAIL armed_disarm_state: got %0d expected %0d", bus.state_o, IDLE); end
    endtask

    task automatic test_reset_mid_delay;
        int n_trig = 0;
        bus.ext_dly_i = 32'd50;
        arm_pulse();
        bus.trig_src_i = 7'b0000001;
        @(negedge clk);
        bus.trig_src_i = '0;
        repeat (4) @(negedge clk);
        n_vec++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL rstdly_busy_before: got %b expected 1", bus.busy_o); end
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.trig_o !== 1'b0) begin n_err++; $display("FAIL rstdly_trig: got %b expected 0", bus.trig_o); end
        n_vec++; if (bus.trig_src_o !== 7'b0) begin n_err++; $display("FAIL rstdly_src: got %b expected 0", bus.trig_src_o); end
        n_vec++; if (bus.trig_cnt_o !== 32'd0) begin n_err++; $display("FAIL rstdly_cnt: got %0d expected 0", bus.trig_cnt_o); end
        n_vec++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rstdly_busy: got %b expected 0", bus.busy_o); end
        n_vec++; if (bus.dly_cnt_o !== 32'd0) begin n_err++; $display("FAIL rstdly_dly_cnt: got %0d expected 0", bus.dly_cnt_o); end
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.trig_o === 1'b1) n_trig++;
        end
        n_vec++; if (n_trig !== 0) begin n_err++; $display("FAIL rstdly_late_trig: got %0d expected 0", n_trig); end
    endtask

    task automatic test_clr_fire;
        bus.trig_en_i = 7'h7F;
        arm_pulse();
        bus.trig_src_i = 7'b0000010; bus.cnt_clr_i = 1'b1;
        @(negedge clk);
        bus.trig_src_i = '0; bus.cnt_clr_i = 1'b0;
        n_vec++; if (bus.trig_o !== 1'b1) begin n_err++; $display("FAIL clrfire_trig: got %b expected 1", bus.trig_o); end
        n_vec++; if (bus.trig_cnt_o !== 32'd0) begin n_err++; $display("FAIL clrfire_cnt: got %0d expected 0", bus.trig_cnt_o); end
    endtask

    task automatic test_cnt_wrap;
        bus_w.trig_en_i = 7'h7F;
        for (int i = 1; i <= 8; i++) begin
            bus_w.arm_i = 1'b1;
            @(negedge clk);
            bus_w.arm_i = 1'b0;
            bus_w.trig_src_i = 7'b0000010;
            @(negedge clk);
            bus_w.trig_src_i = '0;
            if (i == 7) begin
                n_vec++; if (bus_w.trig_cnt_o !== 3'd7) begin n_err++; $display("FAIL wrap_max: got %0d expected 7", bus_w.trig_cnt_o); end
            end
        end
        n_vec++; if (bus_w.trig_o !== 1'b1) begin n_err++; $display("FAIL wrap_trig: got %b expected 1", bus_w.trig_o); end
        n_vec++; if (bus_w.trig_cnt_o !== 3'd0) begin n_err++; $display("FAIL wrap_cnt: got %0d expected 0", bus_w.trig_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_sw_only();
        test_ext_delay();
        test_mixed();
        test_ext_short();
        test_multi_shot();
        test_abort();
        test_arm_edges();
        test_reset_mid_delay();
        test_clr_fire();
        test_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fmc_adc_trig_sequencer.md
Name: fmc_adc_trig_sequencer

Overview:
Trigger arbiter and sequencer between the trigger sources and the acquisition FSM of the FMC-ADC core. It merges the enabled sources (external, software, time, CH1..CH4 threshold) and applies the programmable external-trigger delay. It delivers exactly one qualified trigger pulse per armed shot and records which sources caused it. The acquisition FSM re-arms it once per shot in multi-shot mode.

Parameters:
g_DLY_WIDTH, 32, width of external-trigger delay and counter (sys_clk cycles)
g_CNT_WIDTH, 32, width of accepted-trigger counter

Ports:
sys_clk_i  in  1  system clock (125 MHz)
sys_rst_n_i  in  1  synchronous active-low reset
arm_i  in  1  single-cycle pulse: acq FSM waiting for trigger of next shot
disarm_i  in  1  single-cycle pulse: acquisition stop/abort
trig_en_i  in  7  per-source enable mask (index per package constants)
trig_src_i  in  7  per-source single-cycle trigger pulses, already in sys_clk domain
ext_dly_i  in  g_DLY_WIDTH  external trigger delay in cycles
cnt_clr_i  in  1  clears trig_cnt_o
trig_o  out  1  single-cycle qualified trigger to acq FSM
trig_src_o  out  7  sources active in the accepted cycle, held until next accept
trig_cnt_o  out  g_CNT_WIDTH  number of triggers fired
busy_o  out  1  high in ARMED or DELAY
missed_o  out  1  single-cycle pulse: enabled source ignored while in DELAY

Behaviour:
- Reset (sys_rst_n_i low at clock edge): state IDLE; all outputs 0; delay counter 0.
- hit = trig_src_i & trig_en_i, evaluated each cycle.
- IDLE:
  - arm_i -> ARMED next cycle.
  - hit ignored; no missed_o pulse.
- ARMED:
  - disarm_i -> IDLE.
  - Else, if hit != 0:
    - Latch trig_src_o <= hit.
    - If hit == ext-only and ext_dly_i != 0: load counter <= ext_dly_i, go to DELAY.
    - Otherwise: fire.
- DELAY:
  - disarm_i -> IDLE, no fire; trig_src_o keeps its latched value.
  - Else counter decrements each cycle; fire when counter == 1 and decrements to 0.
  - Any hit != 0 in DELAY -> missed_o pulse one cycle later; pending trigger unaffected.
- Fire:
  - trig_o = 1 for exactly one cycle, registered.
  - trig_cnt_o increments, wrapping 2^g_CNT_WIDTH-1 -> 0.
  - State -> IDLE. One trigger per arm.
- Latency:
  - Hit sampled in cycle t with no delay -> trig_o in t+1.
  - Ext with delay D -> trig_o in t+1+D.
  - D=1 -> t+2.
- ext_dly_i sampled only at accept; changes during DELAY have no effect. Same for trig_en_i.
- Mixed hit (ext plus any other source) fires immediately, ignoring delay; trig_src_o shows all bits.
- Simultaneous events:
  - arm_i and disarm_i in same cycle: disarm wins, stay/go IDLE.
  - arm_i in ARMED or DELAY: ignored.
  - hit in the cycle of arm_i (IDLE): not accepted.
- cnt_clr_i and fire in same cycle: counter = 0, clear wins.
- busy_o is combinational from state: high in ARMED and DELAY.

Decomposition:
- Package fmc_adc_trig_pkg holds:
  - Source index constants: c_TRIG_SRC_EXT=0, c_TRIG_SRC_SW=1, c_TRIG_SRC_TIME=2, c_TRIG_SRC_CH1..CH4=3..6, c_NB_TRIG_SRC=7.
  - State enum t_trig_seq_state {IDLE, ARMED, DELAY}.
- The delay counter is the natural sub-module: fmc_adc_trig_dly_cnt (load, decrement, done pulse, clear).

Test Plan:
- SW only: arm, sw pulse at cycle t -> trig_o at t+1, trig_src_o=7'b0000010, trig_cnt_o=1, busy_o low after.
- Ext, ext_dly_i=3: arm, ext pulse at t -> trig_o at t+4; ch1 pulse during DELAY -> one missed_o pulse, single trig_o.
- Ext+CH3 same cycle, ext_dly_i=10 -> trig_o at t+1, trig_src_o=7'b0100001.
- Multi-shot: 3 arm/sw-trigger cycles -> 3 trig_o pulses, trig_cnt_o=3; extra sw pulse while IDLE -> no trig_o, no missed_o.
- Abort: ext_dly_i=100, ext accepted, disarm_i at t+20 -> no trig_o, state IDLE, trig_cnt_o unchanged.
- Edge cases:
  - arm_i+disarm_i together -> stays IDLE.
  - Counter preloaded to 2^32-1 -> fire wraps to 0.
  - cnt_clr_i coincident with fire -> 0.
  - Reset mid-DELAY -> all outputs 0, no trig_o.
